// File: rtl/acc_core_pkg.sv
// Shared opcode values and FSM state encoding for the acc_core accumulator processor.
package acc_core_pkg;

    localparam logic [2:0] OP_LDI  = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_LD   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_BEQZ = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/acc_regfile.sv
// General register file: one combinational read port, one synchronous write port, cleared on reset.
module acc_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int RS_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RS_W-1:0]   raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [RS_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/acc_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM/HALT sequencer, PC, accumulator with carry,
// ALU and a request/ready memory port shared by instruction fetch and data access.
module acc_core
    import acc_core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out
);

    localparam int IMM_W = DATA_W - 3;
    localparam int RS_W  = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t            state;
    logic              active;
    logic              carry;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic [2:0]        opcode;
    logic [IMM_W-1:0]  imm;
    logic [RS_W-1:0]   rs;
    logic [DATA_W:0]   alu_sum;

    assign opcode   = instr[DATA_W-1 -: 3];
    assign imm      = instr[IMM_W-1:0];
    assign rs       = imm[RS_W-1:0];
    assign imm_sext = {{3{imm[IMM_W-1]}}, imm};

    // SUB is acc + ~r + 1, so the top bit is the no-borrow flag.
    always_comb begin
        if (opcode == OP_SUB) begin
            alu_sum = {1'b0, acc} + {1'b0, ~rd} + (DATA_W+1)'(1);
        end else begin
            alu_sum = {1'b0, acc} + {1'b0, rd};
        end
    end

    // Handshake: a transfer happens in a cycle where mem_req and mem_ready are both high;
    // req/we/addr/wdata derive only from registers and hold until then. ready is ignored
    // while mem_req is low. 'active' keeps the port quiet for the cycle after reset.
    assign mem_req   = active && (state == ST_FETCH || state == ST_MEM);
    assign mem_we    = active && (state == ST_MEM) && (opcode == OP_ST);
    assign mem_addr  = (state == ST_MEM) ? acc[ADDR_W-1:0] : pc;
    assign mem_wdata = rd;

    assign rf_we    = ((state == ST_EXEC) && (opcode == OP_MOV)) ||
                      ((state == ST_MEM) && (opcode == OP_LD) && mem_req && mem_ready);
    assign rf_wdata = (state == ST_MEM) ? mem_rdata : acc;

    acc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .RS_W   (RS_W)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .raddr (rs),
        .rdata (rd),
        .we    (rf_we),
        .waddr (rs),
        .wdata (rf_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_FETCH;
            active <= 1'b0;
            pc     <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            instr  <= '0;
            halted <= 1'b0;
        end else begin
            active <= 1'b1;
            case (state)
                ST_FETCH: begin
                    if (mem_req && mem_ready) begin
                        instr <= mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (opcode)
                        OP_LDI:  acc <= imm_sext;
                        OP_MOV:  ;
                        OP_ADD,
                        OP_SUB:  {carry, acc} <= alu_sum;
                        OP_LD,
                        OP_ST:   state <= ST_MEM;
                        // Overrides the pc already advanced during FETCH.
                        OP_BEQZ: if (acc == '0) pc <= rd[ADDR_W-1:0];
                        OP_HALT: begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_req && mem_ready) begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: ;
            endcase
        end
    end

    assign pc_out  = pc;
    assign acc_out = acc;

endmodule
